// File: rtl/imultf_gen_pkg.sv
// Shared definitions for the imultf_gen iterative fractional multiplier:
// FSM state encodings and a small clog2 helper.
package imultf_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RND  = 2'd2
  } imultf_state_e;

  function automatic int imultf_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/imultf_step.sv
// One combinational shift-add bit step of the fractional multiplier.
// Several instances are chained to retire more than one multiplier bit per clock.
module imultf_step
  import imultf_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   m,
  input  logic               sgn,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH-1:0] hi;
  logic             ext;
  logic [WIDTH:0]   sum;

  assign hi  = acc_in[2*WIDTH-1:WIDTH];
  assign ext = hi[WIDTH-1] & sgn;
  // One extra bit keeps the signed partial sum exact before the shift.
  assign sum = {ext, hi} + {m[WIDTH-1] & sgn, m};

  assign acc_out = acc_in[0] ? {sum, acc_in[WIDTH-1:1]}
                             : {ext, acc_in[2*WIDTH-1:1]};

endmodule

// File: rtl/imultf_gen.sv
// Iterative fractional multiplier retiring STEP multiplier bits per clock.
// Define IMULTF_ROUND_EN to add the rnd port and a round-to-nearest pass on the high half.
module imultf_gen
  import imultf_gen_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               sign,
  input  logic [CW-1:0]      bits,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef IMULTF_ROUND_EN
  input  logic               rnd,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam logic [CW-1:0] MAX_BITS = CW'(WIDTH - 1);

  if ((STEP != 1) && (STEP != 2)) begin : g_bad_step
    $error("imultf_gen: STEP must be 1 or 2");
  end
  if ((STEP == 2) && ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("imultf_gen: WIDTH must be even when STEP is 2");
  end

  imultf_state_e      state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               sgn_q, sgn_d;
  logic               done_q, done_d;
`ifdef IMULTF_ROUND_EN
  logic               rnd_q, rnd_d;
`endif

  logic [CW-1:0]      bits_n;
  logic [CW-1:0]      count_init;
  logic [2*WIDTH-1:0] acc_s0, acc_s1;

  imultf_step #(.WIDTH(WIDTH)) u_step0 (
    .acc_in (acc_q),
    .m      (m_q),
    .sgn    (sgn_q),
    .acc_out(acc_s0)
  );

  if (STEP == 2) begin : g_two
    imultf_step #(.WIDTH(WIDTH)) u_step1 (
      .acc_in (acc_s0),
      .m      (m_q),
      .sgn    (sgn_q),
      .acc_out(acc_s1)
    );
  end else begin : g_one
    assign acc_s1 = acc_s0;
  end

  // Out-of-range precision only occurs for non-power-of-two widths.
  assign bits_n     = (bits > MAX_BITS) ? MAX_BITS : bits;
  assign count_init = (STEP == 2) ? (bits_n >> 1) : bits_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef IMULTF_ROUND_EN
      rnd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
`ifdef IMULTF_ROUND_EN
      rnd_q   <= rnd_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    m_d     = m_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
`ifdef IMULTF_ROUND_EN
    rnd_d   = rnd_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          sgn_d   = sign;
          m_d     = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          count_d = count_init;
`ifdef IMULTF_ROUND_EN
          rnd_d   = rnd;
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_s1;
        if (count_q == '0) begin
`ifdef IMULTF_ROUND_EN
          if (rnd_q) begin
            state_d = ST_RND;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          count_d = count_q - 1'b1;
        end
      end
`ifdef IMULTF_ROUND_EN
      ST_RND: begin
        acc_d   = {acc_q[2*WIDTH-1:WIDTH] + WIDTH'(acc_q[WIDTH-1]), acc_q[WIDTH-1:0]};
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign p    = acc_q;

endmodule
